sort_input_packer: RTL and testbench
====================================

SORT_INPUT_PACKER -- requirements
Module: sort_input_packer

Interface
REQ-001 Parameter N, default 4: number of elements per frame; N >= 2.
REQ-002 Parameter BW, default 8: element width in bits.
REQ-003 Parameter PAD, default all-ones BW-bit value: fill value for flushed short frames.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_data holds an element.
REQ-007 in_ready  output  1  packer accepts an element this cycle.
REQ-008 in_data  input  BW  element value.
REQ-009 in_flush  input  1  close the current partial frame, padding with PAD.
REQ-010 out_valid  output  1  out_frame holds a complete frame.
REQ-011 out_ready  input  1  downstream sorter consumes out_frame this cycle.
REQ-012 out_frame  output  N*BW  packed frame; element i in bits [i*BW +: BW].
REQ-013 out_pad_cnt  output  clog2(N+1)  number of PAD elements in out_frame.

Function
REQ-014 Element accept when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 Two storage slots: a collect register with fill counter fill_cnt (0..N) and an output register with out_valid.
REQ-016 First accepted element of a frame is placed at index 0, the k-th at index k-1.
REQ-017 in_ready = (fill_cnt < N); purely a function of registered state, no combinational path from out_ready.
REQ-018 Output slot is free at an edge when out_valid==0 or out_ready==1 in that cycle.
REQ-019 On accepting the N-th element with output slot free, the completed frame is written to the output register at that edge, out_valid=1 next cycle, fill_cnt returns to 0 (1-cycle latency).
REQ-020 On accepting the N-th element with output slot busy, fill_cnt becomes N and in_ready drops (stall state).
REQ-021 In stall state, the frame moves to the output register at the first edge where out_ready==1; fill_cnt becomes 0 at that edge.
REQ-022 in_flush with 0 < fill_cnt < N and output slot free: frame sent with indices fill_cnt..N-1 set to PAD, out_pad_cnt = N - fill_cnt, fill_cnt cleared.
REQ-023 in_flush with output slot busy: flush is latched (pending) and executes at the first edge the slot is free; no element is accepted while flush is pending (in_ready=0).
REQ-024 in_flush coincident with an accepted element: the element is included first, then padding applied; if that element completes the frame, out_pad_cnt = 0.
REQ-025 in_flush with fill_cnt == 0 and no accept that cycle: ignored, no frame emitted.
REQ-026 out_frame and out_pad_cnt hold stable while out_valid && !out_ready.
REQ-027 out_valid clears at the transfer edge unless a new frame is loaded at that same edge (back-to-back frames, no bubble).
REQ-028 Sustained throughput: one element per cycle while out_ready stays high.

Reset
REQ-029 While rstn==0 at a rising edge: fill_cnt=0, flush-pending=0, out_valid=0, out_frame=0, out_pad_cnt=0.
REQ-030 in_ready is 1 in the first cycle after reset release.
REQ-031 Reset mid-frame discards partially collected elements and any held output frame; no frame emitted after release until N new elements or a flush.

Structure
REQ-032 Shared package holds default N, BW, PAD and the pad-count width function; the downstream sorter imports the same package.
REQ-033 Single module, no sub-modules; collect and output registers implemented as flat N*BW vectors.

Verification
REQ-034 Reset release, feed 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 -> out_frame=0x44332211, out_pad_cnt=0, out_valid one cycle after fourth accept.
REQ-035 out_ready=0, feed 8 elements continuously -> first frame held stable, in_ready drops after eighth accept... after 8th element fill_cnt=N; raise out_ready -> two frames delivered in order, no loss, no duplicates.
REQ-036 Feed 0xA0,0xA1 then in_flush -> out_frame=0xFFFFA1A0, out_pad_cnt=2.
REQ-037 in_flush with fill_cnt==0 -> no out_valid; in_flush together with 4th element -> out_pad_cnt=0.
REQ-038 Assert rstn=0 after 2 accepted elements, release, feed 4 new elements -> only those 4 appear in out_frame.
REQ-039 Random in_valid/out_ready over 1000 cycles against a scoreboard -> every element delivered once, in order, at its index; out_frame stable while stalled.

Source files
------------

// File: rtl/sort_input_packer_pkg.sv
// Shared defaults for the sort input packer and the downstream sorter.
// Both sides import this so frame geometry and pad-count width always agree.
package sort_input_packer_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_BW = 8;
    localparam logic [DEF_BW-1:0] DEF_PAD = '1;

    // Width needed to count 0..n pad elements.
    function automatic int padCntWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sort_input_packer.sv
// Collects a stream of elements into N-wide frames for the sorter, padding short
// frames on flush. A collect register feeds a single registered output slot.
module sort_input_packer
    import sort_input_packer_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int BW = DEF_BW,
    parameter logic [BW-1:0] PAD = '1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BW-1:0]               in_data,
    input  logic                        in_flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N*BW-1:0]             out_frame,
    output logic [padCntWidth(N)-1:0]   out_pad_cnt
);

    localparam int CW = padCntWidth(N);
    localparam logic [CW-1:0] FULL = CW'(N);

    logic [CW-1:0]   fillCnt;
    logic            flushPend;
    logic [N*BW-1:0] collectReg;

    logic            accept;
    logic            slotFree;
    logic            flushReq;
    logic            loadOut;
    logic            nextFlushPend;
    logic [CW-1:0]   nextCnt;
    logic [CW-1:0]   nextFill;
    logic [CW-1:0]   loadPad;
    logic [N*BW-1:0] nextCollect;
    logic [N*BW-1:0] loadFrame;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = (fillCnt < FULL) && !flushPend;
    assign accept   = in_valid && in_ready;
    assign slotFree = !out_valid || out_ready;
    assign flushReq = in_flush || flushPend;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        nextCollect   = collectReg;
        nextCnt       = fillCnt;
        loadOut       = 1'b0;
        nextFlushPend = 1'b0;

        if (accept) begin
            nextCollect[int'(fillCnt)*BW +: BW] = in_data;
            nextCnt = fillCnt + 1'b1;
        end

        loadFrame = nextCollect;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(nextCnt)) loadFrame[i*BW +: BW] = PAD;
        end
        loadPad  = FULL - nextCnt;
        nextFill = nextCnt;

        // A full frame (fresh or stalled) wins; a flush of a full frame is a no-op.
        if (nextCnt == FULL) begin
            if (slotFree) begin
                loadOut  = 1'b1;
                nextFill = '0;
            end
        end else if (flushReq && nextCnt != '0) begin
            if (slotFree) begin
                loadOut  = 1'b1;
                nextFill = '0;
            end else begin
                nextFlushPend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fillCnt     <= '0;
            flushPend   <= 1'b0;
            out_valid   <= 1'b0;
            out_frame   <= '0;
            out_pad_cnt <= '0;
        end else begin
            fillCnt   <= nextFill;
            flushPend <= nextFlushPend;
            if (loadOut) begin
                out_valid   <= 1'b1;
                out_frame   <= loadFrame;
                out_pad_cnt <= loadPad;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: collectReg is pure datapath qualified by fillCnt, so it carries no reset.
    always_ff @(posedge clk) begin
        collectReg <= nextCollect;
    end

endmodule

// File: tb/tb_sort_input_packer.sv
// Directed and scoreboarded checks of sort_input_packer with N=4, BW=8, PAD=0xFF.
module tb_sort_input_packer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_frame;
    logic [2:0]  out_pad_cnt;

    int nCompared   = 0;
    int nMismatched = 0;

    sort_input_packer dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_frame(out_frame), .out_pad_cnt(out_pad_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL feed_ready: in_ready=%b required 1 (data %h)", in_ready, d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        nCompared++;
        if (out_valid !== 1'b0 || out_frame !== 32'h0 || out_pad_cnt !== 3'd0) begin
            nMismatched++;
            $display("FAIL reset_state: valid=%b frame=%h pad=%0d required 0/0/0", out_valid, out_frame, out_pad_cnt);
        end
        rstn = 1'b1;
        tick();
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        feed(8'h11); feed(8'h22); feed(8'h33);
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL basic_early: out_valid=%b required 0", out_valid);
        end
        feed(8'h44);
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'h44332211 || out_pad_cnt !== 3'd0) begin
            nMismatched++;
            $display("FAIL basic_frame: valid=%b frame=%h pad=%0d required 1/44332211/0", out_valid, out_frame, out_pad_cnt);
        end
        tick();
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL basic_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            feed(8'(i));
            if (i == 6) begin
                nCompared++;
                if (out_valid !== 1'b1 || out_frame !== 32'h04030201) begin
                    nMismatched++;
                    $display("FAIL stall_hold: valid=%b frame=%h required 1/04030201", out_valid, out_frame);
                end
            end
        end
        nCompared++;
        if (in_ready !== 1'b0 || out_frame !== 32'h04030201) begin
            nMismatched++;
            $display("FAIL stall_full: in_ready=%b frame=%h required 0/04030201", in_ready, out_frame);
        end
        tick();
        out_ready = 1'b1;
        tick();
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'h08070605 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL stall_second: valid=%b frame=%h ready=%b required 1/08070605/1", out_valid, out_frame, in_ready);
        end
        tick();
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL stall_drain: out_valid=%b required 0 (duplicate frame)", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        feed(8'hA0); feed(8'hA1);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'hFFFFA1A0 || out_pad_cnt !== 3'd2) begin
            nMismatched++;
            $display("FAIL flush_pad: valid=%b frame=%h pad=%0d required 1/FFFFA1A0/2", out_valid, out_frame, out_pad_cnt);
        end
        tick();
    endtask

    task automatic test_flush_edges();
        out_ready = 1'b1;
        in_flush = 1'b1;
        tick(); tick();
        in_flush = 1'b0;
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL flush_empty: out_valid=%b required 0", out_valid);
        end
        feed(8'hB0); feed(8'hB1); feed(8'hB2);
        in_flush = 1'b1;
        feed(8'hB3);
        in_flush = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'hB3B2B1B0 || out_pad_cnt !== 3'd0) begin
            nMismatched++;
            $display("FAIL flush_full: valid=%b frame=%h pad=%0d required 1/B3B2B1B0/0", out_valid, out_frame, out_pad_cnt);
        end
        feed(8'hC0);
        in_flush = 1'b1;
        feed(8'hC1);
        in_flush = 1'b0;
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'hFFFFC1C0 || out_pad_cnt !== 3'd2) begin
            nMismatched++;
            $display("FAIL flush_with_elem: valid=%b frame=%h pad=%0d required 1/FFFFC1C0/2", out_valid, out_frame, out_pad_cnt);
        end
        tick();
        // Flush while the output slot is busy must wait and block new elements.
        out_ready = 1'b0;
        feed(8'hD0); feed(8'hD1); feed(8'hD2); feed(8'hD3);
        feed(8'hE0);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        in_valid = 1'b1; in_data = 8'hE9;
        nCompared++;
        if (in_ready !== 1'b0 || out_frame !== 32'hD3D2D1D0) begin
            nMismatched++;
            $display("FAIL flush_pending: in_ready=%b frame=%h required 0/D3D2D1D0", in_ready, out_frame);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'hFFFFFFE0 || out_pad_cnt !== 3'd3) begin
            nMismatched++;
            $display("FAIL flush_deferred: valid=%b frame=%h pad=%0d required 1/FFFFFFE0/3", out_valid, out_frame, out_pad_cnt);
        end
        tick();
        nCompared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL flush_after: valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        feed(8'h55); feed(8'h66);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        feed(8'h71); feed(8'h72); feed(8'h73);
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_mid_early: out_valid=%b required 0", out_valid);
        end
        feed(8'h74);
        nCompared++;
        if (out_valid !== 1'b1 || out_frame !== 32'h74737271) begin
            nMismatched++;
            $display("FAIL reset_mid_frame: valid=%b frame=%h required 1/74737271", out_valid, out_frame);
        end
        // A held output frame is also discarded by reset.
        out_ready = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_held: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0]  q[$];
        logic [31:0] expFrame;
        logic [31:0] heldFrame = '0;
        logic        heldStall = 1'b0;
        int          transfers = 0;
        rstn = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int c = 0; c < 1020; c++) begin
            if (c < 1000) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = 8'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            if (heldStall) begin
                nCompared++;
                if (out_valid !== 1'b1 || out_frame !== heldFrame) begin
                    nMismatched++;
                    $display("FAIL rand_stable: cycle %0d valid=%b frame=%h required 1/%h", c, out_valid, out_frame, heldFrame);
                end
            end
            if (out_valid && out_ready) begin
                transfers++;
                nCompared++;
                if (q.size() < 4) begin
                    nMismatched++;
                    $display("FAIL rand_extra_frame: cycle %0d frame=%h with only %0d elements pending", c, out_frame, q.size());
                end else begin
                    for (int i = 0; i < 4; i++) expFrame[i*8 +: 8] = q.pop_front();
                    if (out_frame !== expFrame || out_pad_cnt !== 3'd0) begin
                        nMismatched++;
                        $display("FAIL rand_frame: cycle %0d frame=%h pad=%0d required %h/0", c, out_frame, out_pad_cnt, expFrame);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            heldStall = out_valid && !out_ready;
            heldFrame = out_frame;
            tick();
        end
        nCompared++;
        if (transfers < 50 || q.size() >= 4) begin
            nMismatched++;
            $display("FAIL rand_progress: %0d frames delivered, %0d elements left", transfers, q.size());
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_flush = 1'b0; out_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_flush_edges();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
